lsu_datos: RTL and testbench
============================

// Module: lsu_datos
// PURPOSE
//  Load/store unit downstream of the ALU: takes the ALU result as the byte address plus rs2 store data.
//  Runs one data-memory transaction over a req/ack bus, with byte-lane enables, load alignment and sign/zero extension.
//  Holds busy to stall the core, then pulses done with the write-back value or an error flag.
//  Bus timeout and misalignment are reported, never silently dropped.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles mem_req_o stays high without mem_ack_i before abort (>=1)
// PORTS
//  clk_i            in   1   single clock, all state on rising edge
//  rst_i            in   1   synchronous, active-high reset
//  lsu_req_i        in   1   start access; sampled only in IDLE
//  lsu_we_i         in   1   1=store, 0=load
//  lsu_funct3_i     in   3   RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  lsu_addr_i       in   32  byte address (ALU result)
//  lsu_wdata_i      in   32  store data (rs2)
//  lsu_busy_o       out  1   high whenever state != IDLE
//  lsu_done_o       out  1   one-cycle completion pulse
//  lsu_error_o      out  1   valid with done: misaligned, illegal funct3 or timeout
//  lsu_rdata_o      out  32  extended load data, valid with done; 0 for stores/errors
//  mem_req_o        out  1   bus request, held until ack or timeout
//  mem_we_o         out  1   bus write
//  mem_addr_o       out  32  word-aligned address {addr[31:2],2'b00}
//  mem_be_o         out  4   byte enables
//  mem_wdata_o      out  32  lane-replicated store data
//  mem_ack_i        in   1   bus completion; rdata valid same cycle
//  mem_rdata_i      in   32  read word
// BEHAVIOUR
//  Reset (sync): state=IDLE; every output 0; timeout counter 0. Abandons any bus transaction in flight.
//  FSM: IDLE -> ACCESS (legal req) | RESP (illegal req); ACCESS -> RESP (ack or timeout); RESP -> IDLE.
//  Legal loads: funct3 000,001,010,100,101. Legal stores: 000,001,010. Anything else is illegal.
//   Illegal funct3 sets error=1.
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Sets error=1 and never asserts mem_req_o.
//  Request accepted at IDLE cycle N:
//   - address, funct3, we and data are latched.
//   - mem_req_o=1 from cycle N+1.
//   - If the request is illegal, RESP at N+1 instead.
//  Store lane mapping:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{b[7:0]}}
//   - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{h[15:0]}}
//   - SW: be=4'b1111, wdata=w
//   - Loads drive the same be pattern with we=0.
//  mem_* outputs are registered and stable while mem_req_o=1.
//  mem_req_o drops the cycle after ack.
//  Ack at ACCESS cycle M -> RESP at M+1: done=1, rdata registered. Zero-wait ack gives done at N+2.
//  Load formatting: shift mem_rdata_i right by 8*addr[1:0].
//   - LB/LH sign-extend bit 7/15.
//   - LBU/LHU zero-extend.
//  Timeout counter counts ACCESS cycles. mem_req_o is high for at most TIMEOUT_CYCLES cycles.
//   - No ack by the last cycle -> RESP with error=1, rdata=0.
//   - Ack on the last cycle wins: normal completion.
//  lsu_req_i outside IDLE is ignored, including in RESP. It is not queued.
//  mem_ack_i outside ACCESS is ignored.
//  done, error and rdata are high/valid only in RESP; they return to 0 in IDLE.
// TESTING
//  LW addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_be=1111; done once; rdata=0xDEADBEEF; error=0.
//  LB/LBU addr=0x103, rdata=0x80123456 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080; mem_addr=0x100.
//  SH addr=0x202, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; done with rdata=0.
//  LW addr=0x101 -> no mem_req_o ever; done+error at N+1; busy exactly 1 cycle.
//  No ack, TIMEOUT_CYCLES=16 -> mem_req_o high exactly 16 cycles; then done+error.
//   Repeat with ack on cycle 16 -> no error.
//  rst_i mid-ACCESS, and lsu_req_i held through RESP -> all outputs 0 next edge; second req accepted only after IDLE.

Source files
------------

// File: rtl/lsu_datos.sv
// Load/store unit: one data-memory access per request over a req/ack bus, with lane
// steering, load extension, misalignment/illegal-funct3 detection and bus timeout.
module lsu_datos #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_error_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    addr_lo;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [CW-1:0] cnt;

    logic          legal_f3;
    logic          misaligned;
    logic          req_ok;
    logic          last_cycle;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    // Request decode on the live inputs, used only while IDLE.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = 32'h0;
        if (lsu_we_i) begin
            legal_f3 = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b001) ||
                       (lsu_funct3_i == 3'b010);
        end else begin
            legal_f3 = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b001) ||
                       (lsu_funct3_i == 3'b010) || (lsu_funct3_i == 3'b100) ||
                       (lsu_funct3_i == 3'b101);
        end
        case (lsu_funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << lsu_addr_i[1:0];
                wdata_new = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = lsu_addr_i[0];
                be_new     = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_new  = {2{lsu_wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = (lsu_addr_i[1:0] != 2'b00);
                be_new     = 4'b1111;
                wdata_new  = lsu_wdata_i;
            end
            default: begin
                be_new    = 4'b0000;
                wdata_new = 32'h0;
            end
        endcase
        req_ok = legal_f3 && !misaligned;
    end

    // Load formatting uses the latched low address bits and funct3.
    always_comb begin
        shifted  = mem_rdata_i >> {addr_lo, 3'b000};
        load_val = shifted;
        case (funct3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign last_cycle = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lsu_req_i) begin
                    state_next = req_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (mem_ack_i || last_cycle) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_lo     <= 2'b00;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            cnt         <= '0;
            lsu_done_o  <= 1'b0;
            lsu_error_o <= 1'b0;
            lsu_rdata_o <= 32'h0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    lsu_done_o  <= 1'b0;
                    lsu_error_o <= 1'b0;
                    lsu_rdata_o <= 32'h0;
                    if (lsu_req_i) begin
                        addr_lo  <= lsu_addr_i[1:0];
                        funct3_q <= lsu_funct3_i;
                        we_q     <= lsu_we_i;
                        cnt      <= '0;
                        if (req_ok) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= lsu_we_i;
                            mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            mem_be_o    <= be_new;
                            mem_wdata_o <= wdata_new;
                        end else begin
                            // Rejected before touching the bus.
                            lsu_done_o  <= 1'b1;
                            lsu_error_o <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack_i || last_cycle) begin
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= 32'h0;
                        mem_be_o    <= 4'b0000;
                        mem_wdata_o <= 32'h0;
                        lsu_done_o  <= 1'b1;
                        // An ack on the final allowed cycle still counts as success.
                        lsu_error_o <= !mem_ack_i;
                        lsu_rdata_o <= (mem_ack_i && !we_q) ? load_val : 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    lsu_done_o  <= 1'b0;
                    lsu_error_o <= 1'b0;
                    lsu_rdata_o <= 32'h0;
                end
            endcase
        end
    end

    assign lsu_busy_o = (state != IDLE);

endmodule

// File: tb/tb_lsu_datos.sv
// Directed bench for lsu_datos; stimulus pushes expected completions, a monitor pops them on done.
module tb_lsu_datos;

    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_funct3_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic        lsu_error_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    lsu_datos #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_error_o(lsu_error_o),
        .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: each done pulse must match the oldest pending expectation.
    always @(negedge clk_i) begin
        if (!rst_i && lsu_done_o) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 33'd1, 33'd0);
            end else begin
                chk("done_resp", {lsu_error_o, lsu_rdata_o}, exp_q.pop_front());
                chk("busy_in_resp", {32'h0, lsu_busy_o}, 33'd1);
            end
        end
    end

    // ack_at: request cycle on which ack is given (0 = never).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_at,
                             input logic [31:0] ack_rdata, input logic exp_req,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic exp_err, input logic [31:0] exp_rdata,
                             input string name);
        int n;
        lsu_req_i    = 1'b1;
        lsu_we_i     = we;
        lsu_funct3_i = f3;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        step();
        lsu_req_i = 1'b0;
        lsu_wdata_i = 32'h1234_5678;
        if (!exp_req) begin
            chk({name, "_no_req"}, {32'h0, mem_req_o}, 33'd0);
            chk({name, "_busy1"}, {32'h0, lsu_busy_o}, 33'd1);
            step();
            chk({name, "_busy_end"}, {32'h0, lsu_busy_o}, 33'd0);
        end else begin
            n = 0;
            while (mem_req_o && n < 40) begin
                n++;
                if (n == 1) begin
                    chk({name, "_addr"}, {1'b0, mem_addr_o}, {1'b0, addr[31:2], 2'b00});
                    chk({name, "_be"}, {29'h0, mem_be_o}, {29'h0, exp_be});
                    chk({name, "_we"}, {32'h0, mem_we_o}, {32'h0, we});
                    if (we) chk({name, "_wdata"}, {1'b0, mem_wdata_o}, {1'b0, exp_wdata});
                end
                if (n == ack_at) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = ack_rdata;
                end
                step();
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hA5A5_A5A5;
            end
            chk({name, "_req_cycles"}, 33'(n), 33'((ack_at == 0) ? T : ack_at));
            step();
            chk({name, "_busy_end"}, {32'h0, lsu_busy_o}, 33'd0);
        end
        step();
    endtask

    initial begin
        rst_i        = 1'b1;
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'b0;
        lsu_funct3_i = 3'b000;
        lsu_addr_i   = 32'h0;
        lsu_wdata_i  = 32'h0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = 32'h0;
        step();
        step();
        chk("rst_busy", {32'h0, lsu_busy_o}, 33'd0);
        chk("rst_done_err_rdata", {lsu_done_o | lsu_error_o, lsu_rdata_o}, 33'd0);
        chk("rst_mem", {mem_req_o | mem_we_o, mem_addr_o | mem_wdata_o | {28'h0, mem_be_o}}, 33'd0);
        rst_i = 1'b0;
        step();

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, "lw");
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456, 1'b1, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80, "lb");
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80123456, 1'b1, 4'b1000, 32'h0, 1'b0, 32'h00000080, "lbu");
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80123456, 1'b1, 4'b1100, 32'h0, 1'b0, 32'hFFFF8012, "lh");
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80123456, 1'b1, 4'b1100, 32'h0, 1'b0, 32'h00008012, "lhu");
        do_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 2, 32'hFFFFFFFF, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0, "sh");
        do_access(1'b1, 3'b000, 32'h301, 32'h0000005A, 1, 32'hFFFFFFFF, 1'b1, 4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0, "sb");
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, "lw_misal");
        do_access(1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, "ld_illegal");
        do_access(1'b1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, "st_illegal");
        do_access(1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0, "timeout");
        do_access(1'b0, 3'b010, 32'h400, 32'h0, T, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, "ack_last");

        // Reset in the middle of an access: no completion, everything cleared.
        lsu_req_i    = 1'b1;
        lsu_we_i     = 1'b1;
        lsu_funct3_i = 3'b010;
        lsu_addr_i   = 32'h500;
        lsu_wdata_i  = 32'h11223344;
        step();
        lsu_req_i = 1'b0;
        step();
        chk("pre_rst_req", {32'h0, mem_req_o}, 33'd1);
        rst_i = 1'b1;
        step();
        chk("mid_rst_busy", {32'h0, lsu_busy_o}, 33'd0);
        chk("mid_rst_req_we", {31'h0, mem_req_o, mem_we_o}, 33'd0);
        chk("mid_rst_bus", {1'b0, mem_addr_o | mem_wdata_o | {28'h0, mem_be_o}}, 33'd0);
        chk("mid_rst_done", {lsu_done_o | lsu_error_o, lsu_rdata_o}, 33'd0);
        rst_i = 1'b0;
        step();
        chk("post_rst_idle", {32'h0, lsu_busy_o}, 33'd0);

        // Request held through RESP: re-accepted only once back in IDLE.
        lsu_req_i    = 1'b1;
        lsu_we_i     = 1'b0;
        lsu_funct3_i = 3'b010;
        lsu_addr_i   = 32'h602;
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b1, 32'h0});
        step();
        chk("held_resp1", {32'h0, lsu_busy_o}, 33'd1);
        step();
        chk("held_idle_gap", {32'h0, lsu_busy_o}, 33'd0);
        step();
        chk("held_resp2", {32'h0, lsu_busy_o}, 33'd1);
        lsu_req_i = 1'b0;
        step();
        chk("held_final_idle", {32'h0, lsu_busy_o}, 33'd0);
        step();
        step();
        chk("pending_done", 33'(exp_q.size()), 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
